// File: rtl/disable_manager.sv
// Motor-drive disable manager: latches disable faults, holds, pauses before re-enable, locks out after repeated faults.
// Optional DISABLE_SYNC_EN inserts a two-flop synchroniser on each Disable channel.
module disable_manager #(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned PAUSE_CYCLES = 160000,
    parameter int unsigned MAX_RETRIES  = 3,
    parameter int unsigned RETRY_W      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   Disable,
    input  logic                Clear,
    output logic                Enable,
    output logic                Pause,
    output logic                Lockout,
    output logic [NUM_CH-1:0]   Fault_Ch,
    output logic [RETRY_W-1:0]  Retry_Cnt
);

    localparam int unsigned CW = $clog2(PAUSE_CYCLES + 1);
    localparam logic [CW-1:0] PTERM = CW'(PAUSE_CYCLES - 1);
    localparam logic [CW-1:0] PFULL = CW'(PAUSE_CYCLES);
    localparam logic [RETRY_W-1:0] MAXR = RETRY_W'(MAX_RETRIES);

    typedef enum logic [1:0] {
        S_RUN,
        S_HOLD,
        S_PAUSE,
        S_LOCKOUT
    } state_t;

    state_t              state, state_n;
    logic [CW-1:0]       pcnt, pcnt_n;
    logic [CW-1:0]       dcnt, dcnt_n;
    logic [RETRY_W-1:0]  retry, retry_n, retry_inc;
    logic [NUM_CH-1:0]   fault, fault_n;
    logic [NUM_CH-1:0]   d;
    logic                d_any;
    logic                lock_hit;

`ifdef DISABLE_SYNC_EN
    logic [NUM_CH-1:0] sync1, sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= Disable;
            sync2 <= sync1;
        end
    end

    assign d = sync2;
`else
    assign d = Disable;
`endif

    assign d_any     = |d;
    assign retry_inc = (retry == '1) ? retry : retry + RETRY_W'(1);
    assign lock_hit  = (MAX_RETRIES != 0) && (retry_inc >= MAXR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_PAUSE;
            pcnt  <= '0;
            dcnt  <= '0;
            retry <= '0;
            fault <= '0;
        end else begin
            state <= state_n;
            pcnt  <= pcnt_n;
            dcnt  <= dcnt_n;
            retry <= retry_n;
            fault <= fault_n;
        end
    end

    always_comb begin
        state_n = state;
        pcnt_n  = pcnt;
        dcnt_n  = dcnt;
        retry_n = retry;
        fault_n = fault;

        case (state)
            S_RUN: begin
                if (d_any) begin
                    fault_n = fault | d;
                    retry_n = retry_inc;
                    dcnt_n  = '0;
                    state_n = lock_hit ? S_LOCKOUT : S_HOLD;
                end else begin
                    // Decay saturates at PAUSE_CYCLES so it can never wrap and re-fire.
                    if (dcnt != PFULL) begin
                        dcnt_n = dcnt + CW'(1);
                    end
                    if (dcnt == PTERM) begin
                        retry_n = '0;
                    end
                end
            end

            S_HOLD: begin
                fault_n = fault | d;
                dcnt_n  = '0;
                if (!d_any) begin
                    state_n = S_PAUSE;
                    pcnt_n  = '0;
                end
            end

            S_PAUSE: begin
                dcnt_n = '0;
                pcnt_n = pcnt + CW'(1);
                if (d_any) begin
                    fault_n = fault | d;
                    retry_n = retry_inc;
                    state_n = lock_hit ? S_LOCKOUT : S_HOLD;
                end else if (pcnt == PTERM) begin
                    state_n = S_RUN;
                end
            end

            S_LOCKOUT: begin
                dcnt_n  = '0;
                fault_n = fault | d;
                if (Clear && !d_any) begin
                    state_n = S_PAUSE;
                    pcnt_n  = '0;
                    retry_n = '0;
                    fault_n = '0;
                end
            end

            default: begin
                state_n = S_PAUSE;
                pcnt_n  = '0;
            end
        endcase
    end

    assign Enable    = (state == S_RUN);
    assign Pause     = (state == S_PAUSE);
    assign Lockout   = (state == S_LOCKOUT);
    assign Fault_Ch  = fault;
    assign Retry_Cnt = retry;

endmodule

// File: tb/tb_disable_manager.sv
// Directed self-checking bench for disable_manager with PAUSE_CYCLES=16 (default build, no synchroniser).
module tb_disable_manager;

    logic       clk;
    logic       rst;
    logic [1:0] dis;
    logic       clr;
    logic       en;
    logic       pa;
    logic       lo;
    logic [1:0] fc;
    logic [3:0] rc;

    int n_checks;
    int n_fail;

    disable_manager #(
        .NUM_CH       (2),
        .PAUSE_CYCLES (16),
        .MAX_RETRIES  (3),
        .RETRY_W      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Disable   (dis),
        .Clear     (clr),
        .Enable    (en),
        .Pause     (pa),
        .Lockout   (lo),
        .Fault_Ch  (fc),
        .Retry_Cnt (rc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic e, input logic p, input logic l,
                       input logic [1:0] f, input logic [3:0] r);
        n_checks++;
        assert (en === e) else begin
            n_fail++;
            $error("FAIL %s Enable: got %b expected %b", tag, en, e);
        end
        n_checks++;
        assert (pa === p) else begin
            n_fail++;
            $error("FAIL %s Pause: got %b expected %b", tag, pa, p);
        end
        n_checks++;
        assert (lo === l) else begin
            n_fail++;
            $error("FAIL %s Lockout: got %b expected %b", tag, lo, l);
        end
        n_checks++;
        assert (fc === f) else begin
            n_fail++;
            $error("FAIL %s Fault_Ch: got %b expected %b", tag, fc, f);
        end
        n_checks++;
        assert (rc === r) else begin
            n_fail++;
            $error("FAIL %s Retry_Cnt: got %0d expected %0d", tag, rc, r);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        dis = 2'b00;
        clr = 1'b0;
        cyc(2);
        chk("reset", 0, 1, 0, 2'b00, 4'd0);

        // Start-up delay: 16 edges of PAUSE before RUN
        rst = 1'b0;
        cyc(15);
        chk("startup_pause", 0, 1, 0, 2'b00, 4'd0);
        cyc(1);
        chk("startup_run", 1, 0, 0, 2'b00, 4'd0);

        // Single fault on channel 0 held for 5 cycles
        dis = 2'b01;
        cyc(1);
        chk("f1_hold", 0, 0, 0, 2'b01, 4'd1);
        cyc(4);
        chk("f1_hold5", 0, 0, 0, 2'b01, 4'd1);
        dis = 2'b00;
        cyc(1);
        chk("f1_pause", 0, 1, 0, 2'b01, 4'd1);
        cyc(15);
        chk("f1_pause_end", 0, 1, 0, 2'b01, 4'd1);
        cyc(1);
        chk("f1_run", 1, 0, 0, 2'b01, 4'd1);

        // Second and third faults without decay reach lockout
        dis = 2'b01;
        cyc(1);
        chk("f2_hold", 0, 0, 0, 2'b01, 4'd2);
        dis = 2'b00;
        cyc(17);
        chk("f2_run", 1, 0, 0, 2'b01, 4'd2);
        dis = 2'b01;
        cyc(1);
        chk("f3_lock", 0, 0, 1, 2'b01, 4'd3);
        dis = 2'b00;
        cyc(2);
        chk("lock_hold", 0, 0, 1, 2'b01, 4'd3);
        dis = 2'b10;
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        dis = 2'b00;
        chk("clr_blocked", 0, 0, 1, 2'b11, 4'd3);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk("clr_pause", 0, 1, 0, 2'b00, 4'd0);
        cyc(15);
        chk("clr_pause_end", 0, 1, 0, 2'b00, 4'd0);
        cyc(1);
        chk("clr_run", 1, 0, 0, 2'b00, 4'd0);

        // Retry count decays after 16 consecutive RUN cycles
        dis = 2'b01;
        cyc(1);
        chk("d_hold", 0, 0, 0, 2'b01, 4'd1);
        dis = 2'b00;
        cyc(17);
        chk("d_run", 1, 0, 0, 2'b01, 4'd1);
        cyc(15);
        chk("d_15", 1, 0, 0, 2'b01, 4'd1);
        cyc(1);
        chk("d_16", 1, 0, 0, 2'b01, 4'd0);
        dis = 2'b10;
        cyc(1);
        chk("d_fault", 0, 0, 0, 2'b11, 4'd1);
        dis = 2'b00;
        cyc(17);
        chk("d_rerun", 1, 0, 0, 2'b11, 4'd1);

        // Clear outside lockout is ignored
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk("clr_in_run", 1, 0, 0, 2'b11, 4'd1);

        // Asynchronous reset mid-run, no clock edge needed
        rst = 1'b1;
        #1;
        chk("async_rst", 0, 1, 0, 2'b00, 4'd0);
        cyc(1);
        rst = 1'b0;
        cyc(16);
        chk("rst_run", 1, 0, 0, 2'b00, 4'd0);

        // Both channels at once, then re-fault on the terminal pause count
        dis = 2'b11;
        cyc(1);
        chk("m_hold", 0, 0, 0, 2'b11, 4'd1);
        dis = 2'b00;
        cyc(1);
        chk("m_pause", 0, 1, 0, 2'b11, 4'd1);
        cyc(15);
        chk("m_pause15", 0, 1, 0, 2'b11, 4'd1);
        dis = 2'b01;
        cyc(1);
        chk("m_refault", 0, 0, 0, 2'b11, 4'd2);

        // Third fault from PAUSE locks out; reset clears lockout immediately
        dis = 2'b00;
        cyc(1);
        chk("m_pause2", 0, 1, 0, 2'b11, 4'd2);
        dis = 2'b01;
        cyc(1);
        chk("m_lock", 0, 0, 1, 2'b11, 4'd3);
        rst = 1'b1;
        #1;
        chk("lock_rst", 0, 1, 0, 2'b00, 4'd0);
        cyc(2);
        rst = 1'b0;
        dis = 2'b00;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
